// File: rtl/i2c_arb_if.sv
// -----------------------------------------------------------------------------
// i2c_arb_if
// Engine-side bus between the i2c_arb arbiter and the shared I2C master engine.
//   m_wr_req, m_rd_req : one-cycle request pulses, arbiter -> engine
//   m_addr, m_wdata    : register address / write data of the granted client
//   m_rd_data          : engine read data, meaningful while m_rd_done is high
//   m_wr_done          : engine write completion pulse
//   m_rd_done          : engine read completion pulse
// Modports: master = arbiter side, slave = engine side.
// -----------------------------------------------------------------------------
interface i2c_arb_if;
    logic       m_wr_req;
    logic       m_rd_req;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rd_data;
    logic       m_wr_done;
    logic       m_rd_done;

    modport master (
        output m_wr_req, m_rd_req, m_addr, m_wdata,
        input  m_rd_data, m_wr_done, m_rd_done
    );

    modport slave (
        input  m_wr_req, m_rd_req, m_addr, m_wdata,
        output m_rd_data, m_wr_done, m_rd_done
    );
endinterface

// File: rtl/i2c_arb.sv
// -----------------------------------------------------------------------------
// i2c_arb
// Two-client round-robin arbiter in front of a single I2C master engine. Each
// client may have one single-byte read or write outstanding; the arbiter issues
// it to the engine, waits for the matching completion (or a watchdog timeout)
// and returns done/err/rdata to the owning client.
//   TIMEOUT              : WAIT cycles allowed before aborting with err (>= 1)
//   clk, rst             : clock, synchronous active-high reset
//   cK_wr_req, cK_rd_req : client request pulses (write wins if both)
//   cK_addr, cK_wdata    : client address / write data, held until cK_done
//   cK_rdata             : registered read data, updated on cK_done
//   cK_done, cK_err      : one-cycle completion pulse, err marks a timeout
//   cK_busy              : client has a request pending or in service
//   m                    : engine bus (i2c_arb_if.master)
// -----------------------------------------------------------------------------
module i2c_arb #(
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c0_wr_req,
    input  logic       c0_rd_req,
    input  logic [7:0] c0_addr,
    input  logic [7:0] c0_wdata,
    output logic [7:0] c0_rdata,
    output logic       c0_done,
    output logic       c0_err,
    output logic       c0_busy,
    input  logic       c1_wr_req,
    input  logic       c1_rd_req,
    input  logic [7:0] c1_addr,
    input  logic [7:0] c1_wdata,
    output logic [7:0] c1_rdata,
    output logic       c1_done,
    output logic       c1_err,
    output logic       c1_busy,
    i2c_arb_if.master  m
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    pend;        // per-client request accepted, not yet granted
    logic [1:0]    pend_wr;     // per-client opcode, 1 = write
    logic          owner;       // client currently in service
    logic          last_grant;
    logic          op_wr;       // opcode of the transaction in service
    logic          timed_out;
    logic [CW-1:0] cnt;

    logic [1:0] req_wr;
    logic [1:0] req_any;
    logic [1:0] busy;
    logic       active;
    logic       grant;
    logic       eng_done;

    assign req_wr   = {c1_wr_req, c0_wr_req};
    assign req_any  = req_wr | {c1_rd_req, c0_rd_req};
    assign active   = (state != S_IDLE);
    assign busy     = pend | {active & owner, active & ~owner};
    // Tie goes to the client that did not win last; otherwise the sole requester.
    assign grant    = (&pend) ? ~last_grant : pend[1];
    // Only the completion matching the latched opcode ends the transaction.
    assign eng_done = op_wr ? m.m_wr_done : m.m_rd_done;

    assign c0_busy    = busy[0];
    assign c1_busy    = busy[1];
    assign c0_done    = (state == S_DONE) & ~owner;
    assign c1_done    = (state == S_DONE) & owner;
    assign c0_err     = c0_done & timed_out;
    assign c1_err     = c1_done & timed_out;
    assign m.m_wr_req = (state == S_ISSUE) & op_wr;
    assign m.m_rd_req = (state == S_ISSUE) & ~op_wr;

    // NOTE: state is updated with non-blocking assignments only, so every read
    // inside this block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pend       <= '0;
            pend_wr    <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_wr      <= 1'b0;
            timed_out  <= 1'b0;
            cnt        <= '0;
            m.m_addr   <= '0;
            m.m_wdata  <= '0;
            c0_rdata   <= '0;
            c1_rdata   <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (req_any[k] && !busy[k]) begin
                    pend[k]    <= 1'b1;
                    pend_wr[k] <= req_wr[k];
                end
            end

            case (state)
                S_IDLE: begin
                    // A granted client is busy, so the accept loop above never
                    // sets the same pending bit this cycle.
                    if (|pend) begin
                        owner       <= grant;
                        last_grant  <= grant;
                        pend[grant] <= 1'b0;
                        op_wr       <= pend_wr[grant];
                        m.m_addr    <= grant ? c1_addr : c0_addr;
                        m.m_wdata   <= grant ? c1_wdata : c0_wdata;
                        timed_out   <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        if (!op_wr) begin
                            if (owner) c1_rdata <= m.m_rd_data;
                            else       c0_rdata <= m.m_rd_data;
                        end
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Cleared now so the zero is already visible with err.
                        if (!op_wr) begin
                            if (owner) c1_rdata <= '0;
                            else       c0_rdata <= '0;
                        end
                        timed_out <= 1'b1;
                        state     <= S_DONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/i2c_arb.md
# i2c_arb

Two-client round-robin arbiter that shares the single I2C master engine between two independent requesters, e.g. a sensor-polling FSM and a configuration loader. It captures one single-byte read or write request per client, issues it to the engine as a one-cycle request pulse, and waits for the engine's completion. It then returns read data plus a done/error pulse to the owning client. A watchdog protects clients from a hung bus.

## Interface
- `TIMEOUT`, default 65535: engine cycles allowed between issue and engine done before the transaction is aborted with an error. Must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `c0_wr_req`, `c1_wr_req` in 1: one-cycle write request pulse per client.
- `c0_rd_req`, `c1_rd_req` in 1: one-cycle read request pulse per client.
- `c0_addr`, `c1_addr` in 8: register address. Held stable by the client from request until its done pulse.
- `c0_wdata`, `c1_wdata` in 8: write data. Same stability rule as the address.
- `c0_rdata`, `c1_rdata` out 8: read data. Registered; valid from the done cycle until the next done for that client.
- `c0_done`, `c1_done` out 1: one-cycle completion pulse.
- `c0_err`, `c1_err` out 1: one-cycle pulse coincident with done, on timeout.
- `c0_busy`, `c1_busy` out 1: high while that client has a request pending or in service.
- `m_wr_req`, `m_rd_req` out 1: one-cycle request pulses to the I2C engine.
- `m_addr`, `m_wdata` out 8: latched address and data of the granted client. Stable from ISSUE through WAIT.
- `m_rd_data` in 8: engine read data. Sampled on `m_rd_done`.
- `m_wr_done`, `m_rd_done` in 1: engine completion pulses.

## Operation
- **Per-client pending bit and opcode.**
  - The pending bit is set on a request pulse when that client is not busy.
  - A request pulse while the client is busy is ignored.
  - If wr_req and rd_req arrive in the same cycle, the request is a write; the read is dropped.
- **State machine:** IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE**
  - If any pending bit is set, grant one client, clear its pending bit, latch its opcode, addr and wdata, and go to ISSUE.
  - Round robin: when both are pending, grant the client that was not granted last. `last_grant` resets to 1, so client 0 wins the first tie.
  - Engine done pulses arriving in IDLE are ignored. These are late completions after a timeout or reset.
- **ISSUE**
  - Assert exactly one of `m_wr_req` / `m_rd_req` for exactly one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - Only the done matching the latched opcode counts. A mismatched done is ignored.
  - On a matching done: for reads, capture `m_rd_data` into the owner's rdata register. Go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT - 1` without done, go to DONE with an error flag.
- **DONE**
  - Pulse the owner's done.
  - If timed out, also pulse its err and load 0x00 into its rdata when the op was a read.
  - Go to IDLE.
- `cK_busy` = pending_K OR (state ≠ IDLE AND owner = K).
- Counter width = clog2(TIMEOUT+1). The counter saturates and never wraps.
- **Reset**
  - All outputs are 0, state is IDLE, and both pending bits are cleared.
  - A reset mid-transaction abandons it with no done to the client. Any engine done that follows lands in IDLE and is ignored.

## Timing
- Request pulse at cycle t: pending is visible at t+1; IDLE grants at t+1; `m_*_req` is high during t+2; WAIT starts at t+3.
- Matching engine done sampled at cycle d: client done/err and rdata are visible at d+1; IDLE at d+2.
- Earliest back-to-back issue: `m_*_req` for the next grant is high at d+3.
- Minimum spacing between engine request pulses is 4 cycles.
- A new request from the same client is accepted no earlier than the cycle after its done, because busy drops at d+2.
- A timeout is declared in the cycle where the counter equals `TIMEOUT - 1`; the done/err pulse follows one cycle later.

## Test plan
- **Single write.** Client 0 write, addr 0x3A, data 0x5C; engine returns `m_wr_done` 10 cycles after the request.
  - `m_wr_req` is a single pulse 2 cycles after the request, with `m_addr`=0x3A and `m_wdata`=0x5C.
  - `c0_done` pulses 1 cycle after `m_wr_done`.
  - `c0_err`=0.
- **Read.** Client 1 read, addr 0x10; engine returns `m_rd_data`=0xA7 with `m_rd_done`.
  - `c1_rdata`=0xA7 in the `c1_done` cycle.
  - `c0` outputs are unchanged.
- **Simultaneous requests.** Both clients pulse in the same cycle, repeated 3 times.
  - Grants go c0, c1, c0, c1, c0, c1.
  - Engine requests are never closer than 4 cycles apart.
- **Timeout.** `TIMEOUT`=8, client 0 read, engine never responds.
  - `c0_done` and `c0_err` pulse together; `c0_rdata`=0x00.
  - A `m_rd_done` injected 5 cycles later produces no client pulse.
- **Input edge cases.**
  - Client 0 pulses wr_req and rd_req together: only `m_wr_req` is issued.
  - A second c0 pulse while `c0_busy` is dropped: exactly one `c0_done`.
- **Reset mid-transaction.** Assert `rst` during WAIT.
  - All outputs are 0 on the next cycle and busy is cleared.
  - A later `m_wr_done` is ignored.
  - A fresh request is then serviced normally.
